// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller with memory-mapped enable/pending/vector registers.
// Optional macro INTC_LEVEL_TRIG_EN switches sources from edge capture to level-sensitive pending.
module interrupt_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] BASE_ADDR = 8'hF0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq,
   input  logic [7:0]       addr,
   input  logic [7:0]       w_data,
   input  logic             mem_w_en,
   output logic [7:0]       r_data,
   input  logic             int_ret,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [7:0] SRC_MASK  = 8'((9'd1 << N_SRC) - 9'd1);
   localparam logic [7:0] EN_MASK   = 8'((9'd1 << (N_SRC + 1)) - 9'd1);
   localparam logic [7:0] PEND_ADDR = BASE_ADDR + 8'd1;

   state_t     state_q, state_n;
   logic [7:0] en_q, pend_q, pend_n, irq_x, irq_q, rise_q;
   logic [7:0] eligible, win_oh, grant_vec;
   logic [7:0] vec_q [N_SRC];
   logic       grant, wr_en;

   assign irq_x    = 8'(irq);
   assign wr_en    = mem_w_en && (addr == BASE_ADDR);
   assign eligible = pend_q & (en_q >> 1) & SRC_MASK;
   assign grant    = (state_q == IDLE) && en_q[0] && (eligible != 8'd0);
   assign int_en   = en_q;
   assign state    = state_q;

   // Scan from the highest index down so the lowest eligible source ends up winning.
   always_comb begin
      win_oh    = '0;
      grant_vec = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_oh    = '0;
            win_oh[i] = 1'b1;
            grant_vec = vec_q[i];
         end
      end
   end

`ifdef INTC_LEVEL_TRIG_EN
   // Pending mirrors the synchronised lines; the peripheral clears by dropping irq.
   always_comb begin
      pend_n = irq_q & SRC_MASK;
   end
`else
   // A new edge wins over both W1C and the grant clear of the same bit.
   always_comb begin
      pend_n = pend_q;
      if (mem_w_en && (addr == PEND_ADDR))
         pend_n = pend_n & ~w_data;
      if (grant)
         pend_n = pend_n & ~win_oh;
      pend_n = (pend_n | rise_q) & SRC_MASK;
   end
`endif

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (grant) state_n = REQ;
         REQ:     state_n = SERVICE;
         SERVICE: if (int_ret) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      r_data = '0;
      if (addr == BASE_ADDR)
         r_data = en_q;
      else if (addr == PEND_ADDR)
         r_data = pend_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (addr == BASE_ADDR + 8'(i + 2))
            r_data = vec_q[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         en_q    <= '0;
         pend_q  <= '0;
         irq_q   <= '0;
         rise_q  <= '0;
         int_req <= 1'b0;
         int_vec <= '0;
         for (int i = 0; i < N_SRC; i++)
            vec_q[i] <= '0;
      end else begin
         state_q <= state_n;
         irq_q   <= irq_x;
         rise_q  <= irq_x & ~irq_q;
         pend_q  <= pend_n;
         int_req <= grant;
         if (wr_en)
            en_q <= w_data & EN_MASK;
         // grant_vec is taken from the current register, so a same-cycle vector write is not seen.
         if (grant)
            int_vec <= grant_vec;
         for (int i = 0; i < N_SRC; i++) begin
            if (mem_w_en && (addr == BASE_ADDR + 8'(i + 2)))
               vec_q[i] <= w_data;
         end
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller (default edge-triggered build, N_SRC=4, BASE 8'hF0).
module tb_interrupt_controller;

   localparam logic [7:0] EN_A   = 8'hF0;
   localparam logic [7:0] PEND_A = 8'hF1;
   localparam logic [7:0] VEC_A  = 8'hF2;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic [7:0] addr;
   logic [7:0] w_data;
   logic       mem_w_en;
   logic [7:0] r_data;
   logic       int_ret;
   logic       int_req;
   logic [7:0] int_en;
   logic [7:0] int_vec;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;
   logic [7:0] exp_q[$];

   interrupt_controller #(.N_SRC(4), .BASE_ADDR(8'hF0)) dut (
      .clock    (clock),
      .reset    (reset),
      .irq      (irq),
      .addr     (addr),
      .w_data   (w_data),
      .mem_w_en (mem_w_en),
      .r_data   (r_data),
      .int_ret  (int_ret),
      .int_req  (int_req),
      .int_en   (int_en),
      .int_vec  (int_vec),
      .state    (state)
   );

   always #5 clock = ~clock;

   // One clock edge; any request seen is matched against the scoreboard.
   task automatic step();
      logic [7:0] e;
      @(posedge clock);
      #1;
      cycle++;
      if (int_req === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected cycle %0d: int_req=1 int_vec=%h, required no request", cycle, int_vec);
         end else begin
            e = exp_q.pop_front();
            if (int_vec !== e) begin
               n_fail++;
               $display("FAIL sb_vec cycle %0d: int_vec=%h, required %h", cycle, int_vec, e);
            end
         end
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      addr     = a;
      w_data   = d;
      mem_w_en = 1'b1;
      step();
      mem_w_en = 1'b0;
      addr     = 8'h00;
   endtask

   task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = r_data;
   endtask

   task automatic ret_pulse();
      int_ret = 1'b1;
      step();
      int_ret = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; irq = '0; addr = '0; w_data = '0; mem_w_en = 1'b0; int_ret = 1'b0;
      step(); step();
      reset = 1'b0;
      n_tests++;
      if (int_req !== 1'b0 || int_vec !== 8'h00 || int_en !== 8'h00 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b vec=%h en=%h state=%0d, required 0 00 00 0", int_req, int_vec, int_en, state);
      end
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL reset_pend: pend=%h, required 00", d); end
   endtask

   task automatic test_latency();
      logic [7:0] d;
      bus_write(VEC_A, 8'h40);
      bus_write(EN_A, 8'h03);
      irq[0] = 1'b1;
      exp_q.push_back(8'h40);
      step(); step();
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h01 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL lat_pend: pend=%h req=%b, required 01 0", d, int_req);
      end
      step();
      read_reg(PEND_A, d);
      n_tests++;
      if (int_req !== 1'b1 || int_vec !== 8'h40 || d !== 8'h00) begin
         n_fail++; $display("FAIL lat_grant: req=%b vec=%h pend=%h, required 1 40 00", int_req, int_vec, d);
      end
      step();
      n_tests++;
      if (int_req !== 1'b0 || state !== 2'd2) begin
         n_fail++; $display("FAIL lat_oneshot: req=%b state=%0d, required 0 2", int_req, state);
      end
      irq = '0;
      ret_pulse();
      n_tests++;
      if (state !== 2'd0) begin n_fail++; $display("FAIL lat_ret: state=%0d, required 0", state); end
   endtask

   task automatic test_priority();
      logic [7:0] d;
      bus_write(VEC_A + 8'd1, 8'h11);
      bus_write(VEC_A + 8'd2, 8'h22);
      bus_write(EN_A, 8'h0F);
      irq = 4'b0110;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      step(); step(); step();
      read_reg(PEND_A, d);
      n_tests++;
      if (int_req !== 1'b1 || int_vec !== 8'h11 || d !== 8'h04) begin
         n_fail++; $display("FAIL prio_first: req=%b vec=%h pend=%h, required 1 11 04", int_req, int_vec, d);
      end
      irq = '0;
      step(); step();
      n_tests++;
      if (int_req !== 1'b0 || state !== 2'd2) begin
         n_fail++; $display("FAIL prio_hold: req=%b state=%0d, required 0 2", int_req, state);
      end
      ret_pulse();
      n_tests++;
      if (int_req !== 1'b0 || state !== 2'd0) begin
         n_fail++; $display("FAIL prio_ret: req=%b state=%0d, required 0 0", int_req, state);
      end
      step();
      n_tests++;
      if (int_req !== 1'b1 || int_vec !== 8'h22) begin
         n_fail++; $display("FAIL prio_second: req=%b vec=%h, required 1 22", int_req, int_vec);
      end
      step();
      ret_pulse();
   endtask

   task automatic test_masking();
      logic [7:0] d;
      bus_write(EN_A, 8'h01);
      irq[0] = 1'b1;
      step(); step(); step(); step();
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h01 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL mask_pend: pend=%h req=%b, required 01 0", d, int_req);
      end
      exp_q.push_back(8'h40);
      bus_write(EN_A, 8'h03);
      n_tests++;
      if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_early: req=%b, required 0", int_req); end
      step();
      n_tests++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL mask_unmask: req=%b, required 1", int_req); end
      irq = '0;
      step();
      ret_pulse();
   endtask

   task automatic test_global_off();
      logic [7:0] d;
      bus_write(EN_A, 8'h02);
      irq[0] = 1'b1;
      step();
      irq[0] = 1'b0;
      step(); step(); step();
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h01 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL goff_pend: pend=%h req=%b, required 01 0", d, int_req);
      end
      exp_q.push_back(8'h40);
      bus_write(EN_A, 8'h03);
      step();
      n_tests++;
      if (int_req !== 1'b1 || int_vec !== 8'h40) begin
         n_fail++; $display("FAIL goff_enable: req=%b vec=%h, required 1 40", int_req, int_vec);
      end
      step();
      ret_pulse();
      bus_write(EN_A, 8'h02);
      irq[0] = 1'b1;
      step();
      irq[0] = 1'b0;
      step(); step();
      bus_write(PEND_A, 8'h01);
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL goff_w1c: pend=%h, required 00", d); end
      bus_write(EN_A, 8'h03);
      step(); step();
      n_tests++;
      if (int_req !== 1'b0 || state !== 2'd0) begin
         n_fail++; $display("FAIL goff_noreq: req=%b state=%0d, required 0 0", int_req, state);
      end
   endtask

   task automatic test_nesting();
      logic [7:0] d;
      exp_q.push_back(8'h40);
      irq[0] = 1'b1;
      step(); step(); step();
      n_tests++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_grant: req=%b, required 1", int_req); end
      irq[0] = 1'b0;
      step(); step();
      irq[0] = 1'b1;
      step(); step(); step();
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h01 || int_req !== 1'b0 || state !== 2'd2) begin
         n_fail++; $display("FAIL nest_block: pend=%h req=%b state=%0d, required 01 0 2", d, int_req, state);
      end
      reset = 1'b1;
      irq = '0;
      step();
      reset = 1'b0;
      read_reg(PEND_A, d);
      n_tests++;
      if (d !== 8'h00 || int_req !== 1'b0 || state !== 2'd0 || int_en !== 8'h00) begin
         n_fail++; $display("FAIL nest_reset: pend=%h req=%b state=%0d en=%h, required 00 0 0 00", d, int_req, state, int_en);
      end
   endtask

   task automatic test_readback();
      logic [7:0] d;
      bus_write(VEC_A + 8'd3, 8'hA5);
      read_reg(8'hF5, d);
      n_tests++;
      if (d !== 8'hA5) begin n_fail++; $display("FAIL rb_vec3: r_data=%h, required A5", d); end
      read_reg(8'h10, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL rb_outside: r_data=%h, required 00", d); end
      read_reg(8'hF6, d);
      n_tests++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL rb_past_window: r_data=%h, required 00", d); end
      bus_write(EN_A, 8'hFF);
      read_reg(EN_A, d);
      n_tests++;
      if (d !== 8'h1F || int_en !== 8'h1F) begin
         n_fail++; $display("FAIL rb_en_mask: r_data=%h int_en=%h, required 1F 1F", d, int_en);
      end
   endtask

   task automatic test_back_to_back();
      int s;
      logic [7:0] v;
      bus_write(EN_A, 8'h1F);
      for (int k = 0; k < 6; k++) begin
         s = $urandom_range(0, 3);
         v = 8'($urandom_range(0, 255));
         bus_write(VEC_A + 8'(s), v);
         irq[s] = 1'b1;
         exp_q.push_back(v);
         step(); step(); step();
         n_tests++;
         if (int_req !== 1'b1 || int_vec !== v) begin
            n_fail++; $display("FAIL b2b_src%0d: req=%b vec=%h, required 1 %h", s, int_req, int_vec, v);
         end
         irq = '0;
         step();
         ret_pulse();
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_priority();
      test_masking();
      test_global_off();
      test_nesting();
      test_readback();
      test_back_to_back();
      step(); step();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d requests outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
